// File: rtl/router_dest_reader_if.sv
// Output byte stream of the router destination reader: ready/valid handshake
// with start/end-of-packet markers and the source port of each byte.
interface router_dest_reader_if;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] pkt_data;
  logic       pkt_sop;
  logic       pkt_eop;
  logic [1:0] pkt_port;

  modport master (output pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_port,
                  input  pkt_ready);
  modport slave  (input  pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_port,
                  output pkt_ready);
endinterface

// File: rtl/router_dest_reader.sv
// Round-robin reader for the router's three output FIFOs: pulls one packet at a
// time, forwards it through a 2-entry buffer and checks the XOR parity.
//
// state    | meaning
// IDLE     | pick next valid port, round-robin after last served
// HDR      | issue the header read
// HDR_WAIT | header arrives, load remaining = len+1
// BODY     | read payload + parity while remaining > 0
// DONE     | report pkt_done / parity_err
module router_dest_reader (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        vld_out_0,
  input  logic                        vld_out_1,
  input  logic                        vld_out_2,
  input  logic [7:0]                  data_out_0,
  input  logic [7:0]                  data_out_1,
  input  logic [7:0]                  data_out_2,
  input  logic                        soft_reset_0,
  input  logic                        soft_reset_1,
  input  logic                        soft_reset_2,
  output logic                        read_enb_0,
  output logic                        read_enb_1,
  output logic                        read_enb_2,
  router_dest_reader_if.master        pkt,
  output logic                        pkt_done,
  output logic                        parity_err,
  output logic                        pkt_drop
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HDR_WAIT, S_BODY, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  act, act_nxt, last_srv, last_nxt;
  logic [1:0]  cand1, cand2;
  logic [6:0]  rem;
  logic        inflight, inflight_last;
  logic [7:0]  acc;
  logic [12:0] mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic [2:0]  vld_vec;
  logic        vld_act, sr_act;
  logic [7:0]  din;
  logic        issue, abort, done, capture, pop, room;
  logic [2:0]  fill;

  assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};

  always_comb begin
    vld_act = vld_out_0;
    sr_act  = soft_reset_0;
    din     = data_out_0;
    case (act)
      2'd1: begin vld_act = vld_out_1; sr_act = soft_reset_1; din = data_out_1; end
      2'd2: begin vld_act = vld_out_2; sr_act = soft_reset_2; din = data_out_2; end
      default: ;
    endcase
  end

  assign pkt.pkt_valid = (count != 2'd0);
  assign pkt.pkt_data  = mem[rd_ptr][12:5];
  assign pkt.pkt_sop   = mem[rd_ptr][4];
  assign pkt.pkt_eop   = mem[rd_ptr][3];
  assign pkt.pkt_port  = mem[rd_ptr][1:0];
  assign pop           = pkt.pkt_valid && pkt.pkt_ready;

  // A byte leaving this cycle frees its slot, so reads keep 1 byte/cycle flowing.
  assign fill    = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
  assign room    = (fill < 3'd2);
  assign capture = inflight && !abort;

  assign cand1 = (last_srv == 2'd2) ? 2'd0 : last_srv + 2'd1;
  assign cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    act_nxt   = act;
    last_nxt  = last_srv;
    issue     = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    if (state != S_IDLE && sr_act) begin
      abort     = 1'b1;
      last_nxt  = act;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (vld_vec[cand1])         begin act_nxt = cand1;    state_nxt = S_HDR; end
          else if (vld_vec[cand2])    begin act_nxt = cand2;    state_nxt = S_HDR; end
          else if (vld_vec[last_srv]) begin act_nxt = last_srv; state_nxt = S_HDR; end
        end
        S_HDR: begin
          if (vld_act && room) begin
            issue     = 1'b1;
            state_nxt = S_HDR_WAIT;
          end
        end
        S_HDR_WAIT: state_nxt = S_BODY;
        S_BODY: begin
          if (rem != 7'd0 && vld_act && room) issue = 1'b1;
          if (rem == 7'd0) state_nxt = S_DONE;
        end
        S_DONE: begin
          done      = 1'b1;
          last_nxt  = act;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign read_enb_0 = issue && (act == 2'd0);
  assign read_enb_1 = issue && (act == 2'd1);
  assign read_enb_2 = issue && (act == 2'd2);
  assign pkt_done   = done;
  assign parity_err = done && (acc != 8'h00);
  assign pkt_drop   = abort;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      act           <= 2'd0;
      last_srv      <= 2'd2;
      rem           <= 7'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      acc           <= 8'h00;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      mem[0]        <= 13'd0;
      mem[1]        <= 13'd0;
    end else begin
      act           <= act_nxt;
      last_srv      <= last_nxt;
      inflight      <= issue;
      inflight_last <= issue && (state == S_BODY) && (rem == 7'd1);
      if (state == S_HDR_WAIT && !abort) rem <= {1'b0, din[7:2]} + 7'd1;
      else if (issue && state == S_BODY) rem <= rem - 7'd1;
      if (capture) acc <= (state == S_HDR_WAIT) ? din : (acc ^ din);
      if (abort) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (capture) begin
          mem[wr_ptr] <= {din, state == S_HDR_WAIT, inflight_last, 1'b0, act};
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, capture} - {1'b0, pop};
      end
    end
  end

endmodule
